// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory with a ready handshake, latches them into the instruction register
// and presents the decoded fields to the immediate extender and decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] immediate16,
  output logic [25:0] immediate26,
  output logic        ext_select,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] if_pc_reg;
  logic        if_valid_reg;
  logic        capture;
  logic        rdata_is_syscall;

  // SYSCALL is R-type (opcode 0) with funct 0x0C.
  assign rdata_is_syscall = (imem_rdata[31:26] == 6'd0) && (imem_rdata[5:0] == 6'h0C);

  // State register; reset always returns to the boot cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: redirect overrides everything, a captured SYSCALL halts.
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = S_REQ;
    end else begin
      case (state_reg)
        S_BOOT:  state_next = S_REQ;
        S_REQ:   state_next = (capture && rdata_is_syscall) ? S_HALT : S_REQ;
        S_HALT:  state_next = S_HALT;
        default: state_next = S_BOOT;
      endcase
    end
  end

  // Outputs of the FSM: request only when fetching, no held instruction is
  // blocked by stall, and no redirect is replacing the PC this cycle.
  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state_reg)
      S_REQ:   imem_req = !(if_valid_reg && stall) && !redirect;
      S_HALT:  halted   = 1'b1;
      default: imem_req = 1'b0;
    endcase
    capture = imem_req && imem_ready;
  end

  // PC, instruction register and valid flag; a redirect discards any
  // returned word and squashes the held instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      ir_reg       <= 32'd0;
      if_pc_reg    <= 32'd0;
      if_valid_reg <= 1'b0;
    end else if (redirect) begin
      pc_reg       <= redirect_pc;
      if_valid_reg <= 1'b0;
    end else if (capture) begin
      ir_reg       <= imem_rdata;
      if_pc_reg    <= pc_reg;
      pc_reg       <= pc_reg + 32'd4;
      if_valid_reg <= 1'b1;
    end else begin
      if_valid_reg <= if_valid_reg && stall;
    end
  end

  assign imem_addr   = pc_reg;
  assign if_valid    = if_valid_reg;
  assign if_pc       = if_pc_reg;
  assign if_pc4      = if_pc_reg + 32'd4;
  assign opcode      = ir_reg[31:26];
  assign rs          = ir_reg[25:21];
  assign rt          = ir_reg[20:16];
  assign rd          = ir_reg[15:11];
  assign shamt       = ir_reg[10:6];
  assign funct       = ir_reg[5:0];
  assign immediate16 = ir_reg[15:0];
  assign immediate26 = ir_reg[25:0];
  // J and JAL take the 26-bit target form of the immediate.
  assign ext_select  = (ir_reg[31:26] == 6'b000010) || (ir_reg[31:26] == 6'b000011);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, an asynchronous reset taken
// mid-request, then random traffic against a behavioural fetch model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] immediate16;
  logic [25:0] immediate26;
  logic        ext_select;
  logic        halted;

  int tests = 0;
  int fails = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate16(immediate16), .immediate26(immediate26),
    .ext_select(ext_select), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_halt;
    logic        exp_valid;
    logic [31:0] exp_if_pc;
    logic [31:0] exp_ir;
  } vec_t;

  vec_t vecs[23];
  logic [31:0] mem[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_jump(input logic [31:0] w);
    return (w[31:26] == 6'd2) || (w[31:26] == 6'd3);
  endfunction

  function automatic vec_t mk(input logic rdy, input logic stl, input logic rdr,
                              input logic [31:0] rpc, input logic [31:0] rdata,
                              input logic req, input logic [31:0] addr, input logic hlt,
                              input logic val, input logic [31:0] ifpc, input logic [31:0] ir);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdata = rdata;
    v.exp_req = req; v.exp_addr = addr; v.exp_halt = hlt;
    v.exp_valid = val; v.exp_if_pc = ifpc; v.exp_ir = ir;
    return v;
  endfunction

  // Registered outputs, compared against an expected IR / if_pc / valid.
  task automatic check_regs(input string tag, input logic val, input logic [31:0] ifpc,
                            input logic [31:0] ir);
    check({tag, ".if_valid"}, 32'(if_valid), 32'(val));
    check({tag, ".if_pc"}, if_pc, ifpc);
    check({tag, ".if_pc4"}, if_pc4, ifpc + 32'd4);
    check({tag, ".fields"}, {opcode, rs, rt, rd, shamt, funct}, ir);
    check({tag, ".imm16"}, 32'(immediate16), 32'(ir[15:0]));
    check({tag, ".imm26"}, 32'(immediate26), 32'(ir[25:0]));
    check({tag, ".ext_select"}, 32'(ext_select), 32'(is_jump(ir)));
  endtask

  task automatic apply(input vec_t v, input int idx);
    imem_ready  = v.rdy;
    stall       = v.stl;
    redirect    = v.rdr;
    redirect_pc = v.rpc;
    imem_rdata  = v.rdata;
    #1;
    check($sformatf("v%0d.imem_req", idx), 32'(imem_req), 32'(v.exp_req));
    check($sformatf("v%0d.imem_addr", idx), imem_addr, v.exp_addr);
    check($sformatf("v%0d.halted", idx), 32'(halted), 32'(v.exp_halt));
    @(posedge clk);
    @(negedge clk);
    check_regs($sformatf("v%0d", idx), v.exp_valid, v.exp_if_pc, v.exp_ir);
    $display("[TB] vec %0d rdy=%0b stall=%0b redir=%0b -> valid=%0b if_pc=%h ir=%h",
             idx, v.rdy, v.stl, v.rdr, if_valid, if_pc, {opcode, rs, rt, rd, shamt, funct});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_pc, m_ir, m_if_pc, word, rpc;
    logic        m_valid, m_boot, m_stop, rdy, stl, rdr, exp_req, got;

    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    //            rdy stl rdr rpc           rdata          req addr          hlt val if_pc         ir
    vecs[0]  = mk(1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         32'h2008_0005, 1, 32'h0,         0, 1, 32'h0,         32'h2008_0005);
    vecs[2]  = mk(1, 0, 0, 32'h0,         32'h0800_0040, 1, 32'h4,         0, 1, 32'h4,         32'h0800_0040);
    vecs[3]  = mk(0, 0, 0, 32'h0,         32'hDEAD_0000, 1, 32'h8,         0, 0, 32'h4,         32'h0800_0040);
    vecs[4]  = mk(0, 0, 0, 32'h0,         32'hDEAD_0000, 1, 32'h8,         0, 0, 32'h4,         32'h0800_0040);
    vecs[5]  = mk(0, 0, 0, 32'h0,         32'hDEAD_0000, 1, 32'h8,         0, 0, 32'h4,         32'h0800_0040);
    vecs[6]  = mk(1, 0, 0, 32'h0,         32'h2009_0007, 1, 32'h8,         0, 1, 32'h8,         32'h2009_0007);
    vecs[7]  = mk(1, 1, 0, 32'h0,         32'hDEAD_BEEF, 0, 32'hC,         0, 1, 32'h8,         32'h2009_0007);
    vecs[8]  = mk(1, 1, 0, 32'h0,         32'hDEAD_BEEF, 0, 32'hC,         0, 1, 32'h8,         32'h2009_0007);
    vecs[9]  = mk(1, 0, 0, 32'h0,         32'h3C01_1234, 1, 32'hC,         0, 1, 32'hC,         32'h3C01_1234);
    vecs[10] = mk(1, 0, 1, 32'h100,       32'hFFFF_FFFF, 0, 32'h10,        0, 0, 32'hC,         32'h3C01_1234);
    vecs[11] = mk(1, 0, 0, 32'h0,         32'h2400_0001, 1, 32'h100,       0, 1, 32'h100,       32'h2400_0001);
    vecs[12] = mk(1, 1, 1, 32'h20,        32'hFFFF_FFFF, 0, 32'h104,       0, 0, 32'h100,       32'h2400_0001);
    vecs[13] = mk(1, 0, 0, 32'h0,         32'h0000_000C, 1, 32'h20,        0, 1, 32'h20,        32'h0000_000C);
    vecs[14] = mk(1, 0, 0, 32'h0,         32'h2008_0001, 0, 32'h24,        1, 0, 32'h20,        32'h0000_000C);
    vecs[15] = mk(1, 1, 0, 32'h0,         32'h2008_0001, 0, 32'h24,        1, 0, 32'h20,        32'h0000_000C);
    vecs[16] = mk(1, 0, 1, 32'h40,        32'h2008_0001, 0, 32'h24,        1, 0, 32'h20,        32'h0000_000C);
    vecs[17] = mk(1, 0, 0, 32'h0,         32'h2008_0001, 1, 32'h40,        0, 1, 32'h40,        32'h2008_0001);
    vecs[18] = mk(1, 0, 1, 32'hFFFF_FFFC, 32'h0,         0, 32'h44,        0, 0, 32'h40,        32'h2008_0001);
    vecs[19] = mk(1, 0, 0, 32'h0,         32'h0C00_0003, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'h0C00_0003);
    vecs[20] = mk(1, 0, 0, 32'h0,         32'h0000_0020, 1, 32'h0,         0, 1, 32'h0,         32'h0000_0020);
    vecs[21] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'h4,         0, 0, 32'h0,         32'h0000_0020);
    vecs[22] = mk(1, 1, 0, 32'h0,         32'h2000_0000, 1, 32'h4,         0, 1, 32'h4,         32'h2000_0000);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst.imem_req", 32'(imem_req), 32'd0);
    check("rst.imem_addr", imem_addr, 32'h0);
    check("rst.halted", 32'(halted), 32'd0);
    check_regs("rst", 1'b0, 32'h0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a pending request.
    imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    #1;
    check("arst.pre_req", 32'(imem_req), 32'd1);
    check("arst.pre_addr", imem_addr, 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check("arst.imem_req", 32'(imem_req), 32'd0);
    check("arst.imem_addr", imem_addr, 32'h0);
    check("arst.halted", 32'(halted), 32'd0);
    check_regs("arst", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] async reset mid-request done");

    // Random program image with a sprinkling of SYSCALL, J and JAL.
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 9))
        0:       mem[i] = 32'h0000_000C;
        1:       mem[i] = {6'd2, 26'($urandom)};
        2:       mem[i] = {6'd3, 26'($urandom)};
        default: mem[i] = $urandom;
      endcase
    end

    // Behavioural model: a boot cycle, then fetch at pc; stop after SYSCALL
    // until redirected.
    m_pc = 32'h0; m_ir = 32'h0; m_if_pc = 32'h0;
    m_valid = 1'b0; m_boot = 1'b1; m_stop = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 3) == 0);
      rdr = m_stop ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_00FC);
      imem_ready = rdy; stall = stl; redirect = rdr; redirect_pc = rpc;
      imem_rdata = mem[imem_addr[7:2]];
      #1;
      exp_req = !m_boot && !m_stop && !rdr && !(m_valid && stl);
      check($sformatf("r%0d.imem_req", c), 32'(imem_req), 32'(exp_req));
      check($sformatf("r%0d.imem_addr", c), imem_addr, m_pc);
      check($sformatf("r%0d.halted", c), 32'(halted), 32'(m_stop));
      got  = exp_req && rdy;
      word = mem[m_pc[7:2]];
      if (rdr) begin
        m_pc = rpc; m_valid = 1'b0; m_stop = 1'b0;
      end else if (got) begin
        m_ir = word; m_if_pc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1'b1;
        if (word[31:26] == 6'd0 && word[5:0] == 6'h0C) m_stop = 1'b1;
      end else begin
        m_valid = m_valid && stl;
      end
      m_boot = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_regs($sformatf("r%0d", c), m_valid, m_if_pc, m_ir);
      if (got) $display("[TB] rand %0d fetch pc=%h ir=%h", c, m_if_pc, m_ir);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
